// File: rtl/nes_bus_responder.sv
// NES CPU-side bus responder: address decode plus OAM DMA engine.
// The DMA engine halts the CPU and copies one page into PPU OAMDATA.
module nes_bus_responder #(
  parameter logic [15:0] DMA_REG  = 16'h4014,
  parameter logic [15:0] OAM_DATA = 16'h2004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] a,
  input  logic        rw,
  input  logic [7:0]  d_in,
  input  logic [7:0]  bus_din,
  output logic        rdy,
  output logic        dma_active,
  output logic [15:0] bus_a,
  output logic        bus_rw,
  output logic [7:0]  bus_dout,
  output logic        ram_cs,
  output logic [10:0] ram_addr,
  output logic        ppu_cs,
  output logic [2:0]  ppu_reg,
  output logic        apu_cs,
  output logic        cart_cs
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_parity;
  logic [7:0]  r_page;
  logic [7:0]  r_idx;
  logic [7:0]  r_data;
  logic        w_trig;

  assign w_trig = !rw && (a == DMA_REG);

  // State register; reset drops straight back to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Get/put parity, toggles every CPU cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_parity <= 1'b0;
    else       r_parity <= ~r_parity;
  end

  // DMA datapath: latch page on trigger, capture reads, step index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_page <= 8'h00;
      r_idx  <= 8'h00;
      r_data <= 8'h00;
    end else begin
      if (r_state == S_IDLE && w_trig) begin
        r_page <= d_in;
        r_idx  <= 8'h00;
      end
      if (r_state == S_READ) r_data <= bus_din;
      if (r_state == S_WRITE) r_idx <= r_idx + 8'd1;
    end
  end

  // Next state and bus mux; CPU passes through only in IDLE.
  always_comb begin
    w_next     = r_state;
    rdy        = 1'b0;
    dma_active = 1'b1;
    bus_a      = a;
    bus_rw     = 1'b1;
    bus_dout   = r_data;
    unique case (r_state)
      S_IDLE: begin
        rdy        = 1'b1;
        dma_active = 1'b0;
        bus_rw     = rw;
        bus_dout   = d_in;
        if (w_trig) w_next = S_HALT;
      end
      S_HALT: begin
        w_next = r_parity ? S_READ : S_ALIGN;
      end
      S_ALIGN: begin
        w_next = S_READ;
      end
      S_READ: begin
        bus_a  = {r_page, r_idx};
        w_next = S_WRITE;
      end
      S_WRITE: begin
        bus_a  = OAM_DATA;
        bus_rw = 1'b0;
        w_next = (r_idx == 8'hFF) ? S_IDLE : S_READ;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Device decode from the muxed bus address; always one-hot.
  always_comb begin
    ram_cs   = (bus_a[15:13] == 3'b000);
    ppu_cs   = (bus_a[15:13] == 3'b001);
    apu_cs   = (bus_a[15:5] == 11'h200);
    cart_cs  = !(ram_cs || ppu_cs || apu_cs);
    ram_addr = bus_a[10:0];
    ppu_reg  = bus_a[2:0];
  end

endmodule

// File: doc/nes_bus_responder.md
Name: nes_bus_responder

Overview:
- CPU-side bus responder for the NES 6502 core. It receives the address and rw that the CPU drives, and decodes them into device chip selects: internal RAM, PPU registers, APU/IO and cartridge.
- It also owns the OAM DMA engine. A CPU write to $4014 halts the CPU through rdy. The engine then masters the bus and copies 256 bytes from page N*$100 to the PPU OAMDATA register ($2004).
- It sits between the CPU address/data path and the memory-mapped devices.

Parameters:
- DMA_REG, 16'h4014, address that triggers OAM DMA.
- OAM_DATA, 16'h2004, DMA write-target address.

Ports:
- clk  in  1  system clock; one clk = one CPU cycle; all state changes on posedge clk.
- reset  in  1  asynchronous, active-high reset.
- a  in  16  CPU address bus.
- rw  in  1  CPU read/write, 1=read, 0=write.
- d_in  in  8  CPU write data.
- bus_din  in  8  read data returned by the selected device.
- rdy  out  1  CPU ready; 0 halts the CPU.
- dma_active  out  1  high while the DMA engine owns the bus.
- bus_a  out  16  address presented to devices.
- bus_rw  out  1  read/write presented to devices.
- bus_dout  out  8  write data presented to devices.
- ram_cs  out  1  internal RAM select.
- ram_addr  out  11  RAM address, bus_a[10:0] (2KB mirrored).
- ppu_cs  out  1  PPU register select.
- ppu_reg  out  3  PPU register index, bus_a[2:0].
- apu_cs  out  1  APU/IO select.
- cart_cs  out  1  cartridge select.

Behaviour:
- Decode is combinational from bus_a. Exactly one select is high at all times.
  - ram_cs: bus_a[15:13]==0.
  - ppu_cs: bus_a[15:13]==3'b001.
  - apu_cs: $4000..$401F.
  - cart_cs: $4020..$FFFF.
- Bus mux:
  - In IDLE: bus_a=a, bus_rw=rw, bus_dout=d_in (no added latency).
  - In DMA states: the engine drives all three.
- Parity flop toggles every clk; reset value 0. Parity 0 = "get" cycle, parity 1 = "put" cycle.
- Registers: page[7:0], idx[7:0], data[7:0].
- States:
  - IDLE, reset state: rdy=1, dma_active=0.
    - If rw==0 and a==DMA_REG at a posedge: page<=d_in, idx<=0, go to HALT.
    - The $4014 write itself still reaches apu_cs in that cycle.
  - HALT, 1 cycle: rdy=0, dma_active=1, bus_a=a, bus_rw=1 (dummy read).
    - Next state is ALIGN if parity in HALT is 0, else READ. This puts READ on parity 0.
  - ALIGN, 1 cycle: same outputs as HALT; next state READ.
  - READ: bus_a={page,idx}, bus_rw=1; data<=bus_din at the posedge ending the cycle; next state WRITE.
  - WRITE: bus_a=OAM_DATA, bus_rw=0, bus_dout=data.
    - idx<=idx+1, wrapping 8-bit; page never increments.
    - If idx==255, go to IDLE, else go to READ.
- rdy and dma_active are registered from state: rdy=0 from HALT through the final WRITE inclusive.
- Total halt is 513 cycles (1 HALT + 512) or 514 cycles (with ALIGN).
- Boundary cases:
  - A $4014 write in any non-IDLE state is ignored, including the DMA's own bus writes.
  - Any page 00..FF is legal:
    - page $20 reads PPU registers;
    - page $40 reads APU/IO;
    - no special casing.
  - Reset asserted mid-DMA forces IDLE immediately (async):
    - rdy=1, dma_active=0;
    - idx=0, page=0, data=0, parity=0.
- Reset values: rdy=1, dma_active=0; bus_* follow the CPU inputs; selects follow decode of a.

Test Plan:
- Decode sweep: a=$0000/$07FF/$1800 -> ram_cs, ram_addr=000/7FF/000. a=$2000/$3FFF -> ppu_cs, ppu_reg=0/7. a=$4017 -> apu_cs. a=$4020/$FFFF -> cart_cs. Exactly one select is high throughout.
- DMA even start: after reset, write $02 to $4014 so that HALT lands on parity 1 -> no ALIGN. Required: rdy low exactly 513 cycles; 256 READs of $0200..$02FF each followed by a WRITE to $2004 carrying the byte read (model returns addr[7:0]^$A5).
- DMA odd start: same as above, with HALT on parity 0 -> one ALIGN cycle; rdy low exactly 514 cycles; first READ is on parity 0.
- Wrap: page $FF -> last read is $FFFF, then rdy=1 next cycle. bus_a must not touch $0000 during DMA reads.
- Reset mid-DMA: assert reset at idx=$40 -> same cycle rdy=1, dma_active=0, bus_a=a. A new $4014 write with $03 then performs a full 256-byte copy from $0300.
- Ignored retrigger: drive a=$4014, rw=0 on CPU inputs during DMA -> page unchanged, transfer count still 256.
